// File: rtl/axi_chan_scoreboard.sv
// axi_chan_scoreboard: in-order scoreboard for one AXI link.
// Side A is the link ingress and side B the egress. AW/W/AR beats are recorded
// on side A and checked on side B; B/R beats are recorded on side B and
// checked on side A. Each channel has its own FIFO lane with sticky
// mismatch / overflow / underflow flags.
// Optional feature: define AXI_CHAN_SCB_ERR_CNT_EN to build the saturating
// error-event counter on err_cnt_o; otherwise err_cnt_o is tied to zero.
//
// Handshake: a beat fires on a posedge of clk_1 where its valid and ready are
// both high. Valid and ready are only observed, never driven.

// One channel lane: expectation FIFO, compare, sticky flags.
module axi_chan_scb_lane #(
    parameter int Width = 32,
    parameter int Depth = 8
) (
    input  logic             clk_1,
    input  logic             rst_1_n,
    input  logic             live,
    input  logic             clear,
    input  logic             src_fire,
    input  logic [Width-1:0] src_data,
    input  logic             snk_fire,
    input  logic [Width-1:0] snk_data,
    output logic             mismatch,
    output logic             overflow,
    output logic             underflow,
    output logic             pending,
    output logic             err_evt
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             do_cmp;
    logic [Width-1:0] cmp_data;
    logic             mism_evt;
    logic             ovf_evt;
    logic             unf_evt;

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign pending = !empty;
    assign err_evt = mism_evt | ovf_evt | unf_evt;

    // Decide push / pop / compare for this cycle; clear and the first edge
    // after reset release suppress every event.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        do_cmp   = 1'b0;
        cmp_data = mem[rd_ptr];
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (live && !clear) begin
            if (snk_fire) begin
                if (empty) begin
                    if (src_fire) begin
                        // bypass: compare source with sink directly, store nothing
                        do_cmp   = 1'b1;
                        cmp_data = src_data;
                    end else begin
                        unf_evt = 1'b1;
                    end
                end else begin
                    // pop the head; a simultaneous source beat is pushed even when full
                    pop    = 1'b1;
                    do_cmp = 1'b1;
                    push   = src_fire;
                end
            end else if (src_fire) begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
        end
        mism_evt = do_cmp && (cmp_data !== snk_data);
    end

    // Payload storage; a full-FIFO swap overwrites the slot being popped.
    always_ff @(posedge clk_1) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    // Pointers, occupancy and sticky flags.
    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (mism_evt) begin
                mismatch <= 1'b1;
            end
            if (ovf_evt) begin
                overflow <= 1'b1;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

module axi_chan_scoreboard #(
    parameter int AwWidth = 32,
    parameter int WWidth  = 32,
    parameter int ArWidth = 32,
    parameter int BWidth  = 8,
    parameter int RWidth  = 32,
    parameter int Depth   = 8
) (
    input  logic               clk_1,
    input  logic               rst_1_n,
    input  logic               clear_i,
    input  logic               a_aw_valid_i,
    input  logic               a_aw_ready_i,
    input  logic [AwWidth-1:0] a_aw_i,
    input  logic               a_w_valid_i,
    input  logic               a_w_ready_i,
    input  logic [WWidth-1:0]  a_w_i,
    input  logic               a_ar_valid_i,
    input  logic               a_ar_ready_i,
    input  logic [ArWidth-1:0] a_ar_i,
    input  logic               a_b_valid_i,
    input  logic               a_b_ready_i,
    input  logic [BWidth-1:0]  a_b_i,
    input  logic               a_r_valid_i,
    input  logic               a_r_ready_i,
    input  logic [RWidth-1:0]  a_r_i,
    input  logic               b_aw_valid_i,
    input  logic               b_aw_ready_i,
    input  logic [AwWidth-1:0] b_aw_i,
    input  logic               b_w_valid_i,
    input  logic               b_w_ready_i,
    input  logic [WWidth-1:0]  b_w_i,
    input  logic               b_ar_valid_i,
    input  logic               b_ar_ready_i,
    input  logic [ArWidth-1:0] b_ar_i,
    input  logic               b_b_valid_i,
    input  logic               b_b_ready_i,
    input  logic [BWidth-1:0]  b_b_i,
    input  logic               b_r_valid_i,
    input  logic               b_r_ready_i,
    input  logic [RWidth-1:0]  b_r_i,
    output logic [4:0]         mismatch_o,
    output logic [4:0]         overflow_o,
    output logic [4:0]         underflow_o,
    output logic               pending_o,
    output logic [15:0]        err_cnt_o
);
    logic       live;
    logic [4:0] pend;
    logic [4:0] err_evt;

    // Events on the edge that releases reset are not evaluated: live rises
    // only on the first edge after release.
    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    axi_chan_scb_lane #(.Width(AwWidth), .Depth(Depth)) u_aw (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .live(live), .clear(clear_i),
        .src_fire(a_aw_valid_i & a_aw_ready_i), .src_data(a_aw_i),
        .snk_fire(b_aw_valid_i & b_aw_ready_i), .snk_data(b_aw_i),
        .mismatch(mismatch_o[0]), .overflow(overflow_o[0]), .underflow(underflow_o[0]),
        .pending(pend[0]), .err_evt(err_evt[0])
    );

    axi_chan_scb_lane #(.Width(WWidth), .Depth(Depth)) u_w (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .live(live), .clear(clear_i),
        .src_fire(a_w_valid_i & a_w_ready_i), .src_data(a_w_i),
        .snk_fire(b_w_valid_i & b_w_ready_i), .snk_data(b_w_i),
        .mismatch(mismatch_o[1]), .overflow(overflow_o[1]), .underflow(underflow_o[1]),
        .pending(pend[1]), .err_evt(err_evt[1])
    );

    axi_chan_scb_lane #(.Width(ArWidth), .Depth(Depth)) u_ar (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .live(live), .clear(clear_i),
        .src_fire(a_ar_valid_i & a_ar_ready_i), .src_data(a_ar_i),
        .snk_fire(b_ar_valid_i & b_ar_ready_i), .snk_data(b_ar_i),
        .mismatch(mismatch_o[2]), .overflow(overflow_o[2]), .underflow(underflow_o[2]),
        .pending(pend[2]), .err_evt(err_evt[2])
    );

    // Response channels: source is side B, sink is side A.
    axi_chan_scb_lane #(.Width(BWidth), .Depth(Depth)) u_b (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .live(live), .clear(clear_i),
        .src_fire(b_b_valid_i & b_b_ready_i), .src_data(b_b_i),
        .snk_fire(a_b_valid_i & a_b_ready_i), .snk_data(a_b_i),
        .mismatch(mismatch_o[3]), .overflow(overflow_o[3]), .underflow(underflow_o[3]),
        .pending(pend[3]), .err_evt(err_evt[3])
    );

    axi_chan_scb_lane #(.Width(RWidth), .Depth(Depth)) u_r (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .live(live), .clear(clear_i),
        .src_fire(b_r_valid_i & b_r_ready_i), .src_data(b_r_i),
        .snk_fire(a_r_valid_i & a_r_ready_i), .snk_data(a_r_i),
        .mismatch(mismatch_o[4]), .overflow(overflow_o[4]), .underflow(underflow_o[4]),
        .pending(pend[4]), .err_evt(err_evt[4])
    );

    assign pending_o = |pend;

`ifdef AXI_CHAN_SCB_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic [2:0]  evt_sum;
    logic [16:0] cnt_sum;

    // Sum this cycle's error events across all channels.
    always_comb begin
        evt_sum = '0;
        for (int i = 0; i < 5; i++) begin
            evt_sum = evt_sum + 3'(err_evt[i]);
        end
        cnt_sum = {1'b0, err_cnt} + 17'(evt_sum);
    end

    // Saturating error counter, flushed by clear_i.
    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            err_cnt <= '0;
        end else if (clear_i) begin
            err_cnt <= '0;
        end else if (cnt_sum[16]) begin
            err_cnt <= 16'hFFFF;
        end else begin
            err_cnt <= cnt_sum[15:0];
        end
    end

    assign err_cnt_o = err_cnt;
`else
    logic unused_err_evt;
    assign unused_err_evt = ^err_evt;
    assign err_cnt_o      = 16'h0000;
`endif
endmodule

// File: tb/tb_axi_chan_scoreboard.sv
// Directed bench for axi_chan_scoreboard. Expected output words
// {pending, underflow, overflow, mismatch, err_cnt} are queued when a step is
// driven and popped/compared once the clock edge has been taken.
module tb_axi_chan_scoreboard;
  logic        clk_1 = 1'b0;
  logic        rst_1_n;
  logic        clear_i;
  logic        a_aw_valid_i, a_aw_ready_i, b_aw_valid_i, b_aw_ready_i;
  logic        a_w_valid_i,  a_w_ready_i,  b_w_valid_i,  b_w_ready_i;
  logic        a_ar_valid_i, a_ar_ready_i, b_ar_valid_i, b_ar_ready_i;
  logic        a_b_valid_i,  a_b_ready_i,  b_b_valid_i,  b_b_ready_i;
  logic        a_r_valid_i,  a_r_ready_i,  b_r_valid_i,  b_r_ready_i;
  logic [31:0] a_aw_i, b_aw_i, a_w_i, b_w_i, a_ar_i, b_ar_i, a_r_i, b_r_i;
  logic [7:0]  a_b_i, b_b_i;
  logic [4:0]  mismatch_o, overflow_o, underflow_o;
  logic        pending_o;
  logic [15:0] err_cnt_o;

`ifdef AXI_CHAN_SCB_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic [31:0] exp_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  logic [4:0]  e_mism, e_ovf, e_unf;
  logic        e_pend;
  logic [15:0] e_cnt;

  axi_chan_scoreboard dut (
    .clk_1(clk_1), .rst_1_n(rst_1_n), .clear_i(clear_i),
    .a_aw_valid_i(a_aw_valid_i), .a_aw_ready_i(a_aw_ready_i), .a_aw_i(a_aw_i),
    .a_w_valid_i(a_w_valid_i),   .a_w_ready_i(a_w_ready_i),   .a_w_i(a_w_i),
    .a_ar_valid_i(a_ar_valid_i), .a_ar_ready_i(a_ar_ready_i), .a_ar_i(a_ar_i),
    .a_b_valid_i(a_b_valid_i),   .a_b_ready_i(a_b_ready_i),   .a_b_i(a_b_i),
    .a_r_valid_i(a_r_valid_i),   .a_r_ready_i(a_r_ready_i),   .a_r_i(a_r_i),
    .b_aw_valid_i(b_aw_valid_i), .b_aw_ready_i(b_aw_ready_i), .b_aw_i(b_aw_i),
    .b_w_valid_i(b_w_valid_i),   .b_w_ready_i(b_w_ready_i),   .b_w_i(b_w_i),
    .b_ar_valid_i(b_ar_valid_i), .b_ar_ready_i(b_ar_ready_i), .b_ar_i(b_ar_i),
    .b_b_valid_i(b_b_valid_i),   .b_b_ready_i(b_b_ready_i),   .b_b_i(b_b_i),
    .b_r_valid_i(b_r_valid_i),   .b_r_ready_i(b_r_ready_i),   .b_r_i(b_r_i),
    .mismatch_o(mismatch_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .pending_o(pending_o), .err_cnt_o(err_cnt_o)
  );

  // clock / watchdog
  always #5 clk_1 = ~clk_1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle();
    a_aw_valid_i = 0; b_aw_valid_i = 0; a_w_valid_i = 0; b_w_valid_i = 0;
    a_ar_valid_i = 0; b_ar_valid_i = 0; a_b_valid_i = 0; b_b_valid_i = 0;
    a_r_valid_i  = 0; b_r_valid_i  = 0; clear_i = 0;
  endtask

  // channel 0 AW, 1 W, 2 AR, 3 B, 4 R
  task automatic set_src(input int ch, input logic [31:0] d);
    case (ch)
      0: begin a_aw_valid_i = 1; a_aw_i = d; end
      1: begin a_w_valid_i  = 1; a_w_i  = d; end
      2: begin a_ar_valid_i = 1; a_ar_i = d; end
      3: begin b_b_valid_i  = 1; b_b_i  = d[7:0]; end
      default: begin b_r_valid_i = 1; b_r_i = d; end
    endcase
  endtask

  task automatic set_snk(input int ch, input logic [31:0] d);
    case (ch)
      0: begin b_aw_valid_i = 1; b_aw_i = d; end
      1: begin b_w_valid_i  = 1; b_w_i  = d; end
      2: begin b_ar_valid_i = 1; b_ar_i = d; end
      3: begin a_b_valid_i  = 1; a_b_i  = d[7:0]; end
      default: begin a_r_valid_i = 1; a_r_i = d; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic add_err(input int n);
    if (CntEn) e_cnt = e_cnt + 16'(n);
  endtask

  task automatic clear_model();
    e_mism = '0; e_ovf = '0; e_unf = '0; e_pend = 1'b0; e_cnt = '0;
  endtask

  // scoreboard
  task automatic expect_now();
    exp_q.push_back({e_pend, e_unf, e_ovf, e_mism, e_cnt});
  endtask

  task automatic check_out(input string tag);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {pending_o, underflow_o, overflow_o, mismatch_o, err_cnt_o};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        mismatched++;
        $error("FAIL %s: observed {pend,unf,ovf,mism,cnt}=%h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag);
    expect_now();
    tick();
    idle();
    check_out(tag);
  endtask

  initial begin
    int          n;
    logic [31:0] v;

    // reset
    rst_1_n = 1'b1;
    idle();
    a_aw_ready_i = 1; b_aw_ready_i = 1; a_w_ready_i = 1; b_w_ready_i = 1;
    a_ar_ready_i = 1; b_ar_ready_i = 1; a_b_ready_i = 1; b_b_ready_i = 1;
    a_r_ready_i  = 1; b_r_ready_i  = 1;
    a_aw_i = '0; b_aw_i = '0; a_w_i = '0; b_w_i = '0; a_ar_i = '0; b_ar_i = '0;
    a_r_i = '0; b_r_i = '0; a_b_i = '0; b_b_i = '0;
    clear_model();
    repeat (3) tick();
    expect_now();
    check_out("reset_state");
    @(negedge clk_1);
    rst_1_n = 1'b0;
    tick();
    tick();

    // T1: AW pushed, accepted on B three cycles later
    set_src(0, 32'h1000); e_pend = 1; step("t1_push");
    step("t1_wait1");
    step("t1_wait2");
    set_snk(0, 32'h1000); e_pend = 0; step("t1_pop");

    // T2: W payload corrupted by one bit
    set_src(1, 32'hDEAD_BEEF); e_pend = 1; step("t2_push");
    set_snk(1, 32'hDEAD_BEEE); e_pend = 0; e_mism[1] = 1; add_err(1); step("t2_cmp");

    // T3: nine AR beats into an 8-deep FIFO, then drain 0..7
    for (int i = 0; i < 8; i++) begin
      set_src(2, 32'(i)); e_pend = 1; step("t3_fill");
    end
    set_src(2, 32'd8); e_ovf[2] = 1; add_err(1); step("t3_ovf");
    for (int i = 0; i < 8; i++) begin
      set_snk(2, 32'(i)); e_pend = (i != 7); step("t3_drain");
    end

    // T4: R sink on A with nothing expected
    set_snk(4, 32'h55); e_unf[4] = 1; add_err(1); step("t4_unf");

    // T5: B source and sink together on an empty FIFO
    set_src(3, 32'h05); set_snk(3, 32'h05); step("t5_bypass");

    // bypass with differing payloads flags AR
    v = $urandom;
    set_src(2, v); set_snk(2, ~v); e_mism[2] = 1; add_err(1); step("bypass_mism");

    // valid without ready is not a beat
    a_aw_ready_i = 0; set_src(0, 32'h77); step("no_ready");
    a_aw_ready_i = 1;

    // full FIFO: simultaneous pop and push keeps count, no overflow
    for (int i = 0; i < 8; i++) begin
      set_src(0, 32'h10 + 32'(i)); e_pend = 1; step("full_fill");
    end
    set_src(0, 32'h20); set_snk(0, 32'h10); step("full_swap");
    for (int i = 1; i < 8; i++) begin
      set_snk(0, 32'h10 + 32'(i)); step("swap_drain");
    end
    set_snk(0, 32'h20); e_pend = 0; step("swap_last");

    // random traffic on AW and W in parallel
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      v = $urandom; aw_q.push_back(v); set_src(0, v);
      v = $urandom; w_q.push_back(v);  set_src(1, v);
      e_pend = 1; step("rand_push");
    end
    for (int i = 0; i < n; i++) begin
      set_snk(0, aw_q.pop_front());
      set_snk(1, w_q.pop_front());
      e_pend = (i != n - 1); step("rand_pop");
    end

    // T6: reset mid-burst takes effect without a clock edge
    for (int i = 0; i < 3; i++) begin
      set_src(0, 32'h300 + 32'(i)); e_pend = 1; step("t6_fill");
    end
    #2;
    rst_1_n = 1'b1;
    #1;
    clear_model();
    expect_now();
    check_out("t6_async_reset");
    @(negedge clk_1);
    rst_1_n = 1'b0;
    tick();
    tick();
    set_snk(0, 32'h300); e_unf[0] = 1; add_err(1); step("t6_unf_after_reset");

    // T6 variant: clear_i flushes and overrides a same-cycle AR underflow
    for (int i = 0; i < 3; i++) begin
      set_src(1, 32'h400 + 32'(i)); e_pend = 1; step("clr_fill");
    end
    clear_i = 1; set_snk(2, 32'h1);
    clear_model();
    step("clr_flush");
    set_snk(1, 32'h400); e_unf[1] = 1; add_err(1); step("clr_unf_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
